// File: rtl/custom_ip_pkg.sv
// Shared types and constants for the custom_ip frame sequencer.
package custom_ip_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        ARM    = 5'b00010,
        ACTIVE = 5'b00100,
        DRAIN  = 5'b01000,
        GAP    = 5'b10000
    } seq_state_e;

    localparam int NIBBLES_PER_GROUP = 4;
    localparam int SEQ_FRAME_GROUPS  = 324;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/custom_ip_frame_sequencer.sv
// Sequences custom_ip_deserializer: request -> sync align -> one enabled frame -> length check -> gap.
// All outputs registered. Optional CUSTOM_IP_SEQ_STATS_EN adds saturating frame_cnt/err_cnt outputs.
module custom_ip_frame_sequencer
    import custom_ip_pkg::*;
#(
    parameter int FRAME_GROUPS = SEQ_FRAME_GROUPS,
    parameter int MIN_GAP      = 8,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                              clk_75mhz,
    input  logic                              rst,
    input  logic                              start_req,
    input  logic                              continuous,
    input  logic                              abort,
    input  logic                              sync_in,
    input  logic                              pair_valid,
    output logic                              start_ack,
    output logic                              deser_enable,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              frame_ok,
    output logic                              err_timeout,
    output logic [$clog2(FRAME_GROUPS+1)-1:0] group_count
`ifdef CUSTOM_IP_SEQ_STATS_EN
    ,
    output logic [15:0]                       frame_cnt,
    output logic [15:0]                       err_cnt
`endif
);

    localparam int GC_W  = $clog2(FRAME_GROUPS + 1);
    localparam int CYC_W = $clog2(FRAME_GROUPS * NIBBLES_PER_GROUP);
    localparam int TMR_W = $clog2(SYNC_TIMEOUT + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(FRAME_GROUPS * NIBBLES_PER_GROUP - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SYNC_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);
    localparam logic [GC_W-1:0]  GC_FULL  = GC_W'(FRAME_GROUPS);

    seq_state_e       state_q, state_d;
    logic [TMR_W-1:0] sync_tmr_q, sync_tmr_d;
    logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [GAP_W-1:0] gap_tmr_q, gap_tmr_d;
    logic [GC_W-1:0]  gc_q, gc_d;
    logic             start_ack_q, start_ack_d;
    logic             deser_en_q, deser_en_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic             err_to_q, err_to_d;
    logic             pair_inc;

    assign pair_inc = pair_valid && (gc_q != GC_FULL);

    always_comb begin
        state_d      = state_q;
        sync_tmr_d   = sync_tmr_q;
        cyc_cnt_d    = cyc_cnt_q;
        gap_tmr_d    = gap_tmr_q;
        gc_d         = gc_q;
        start_ack_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        err_to_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d     = ARM;
                    start_ack_d = 1'b1;
                    gc_d        = '0;
                    sync_tmr_d  = '0;
                end
            end
            // abort beats sync, sync beats timeout
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sync_in) begin
                    state_d   = ACTIVE;
                    cyc_cnt_d = '0;
                end else if (sync_tmr_q == TMR_LAST) begin
                    state_d  = IDLE;
                    err_to_d = 1'b1;
                end else begin
                    sync_tmr_d = sync_tmr_q + TMR_W'(1);
                end
            end
            ACTIVE: begin
                gc_d = gc_q + GC_W'(pair_inc);
                if (abort) begin
                    state_d      = GAP;
                    gap_tmr_d    = '0;
                    frame_done_d = 1'b1;
                end else if (cyc_cnt_q == CYC_LAST) begin
                    state_d = DRAIN;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end
            // the deserializer's last pair strobe lands here, one cycle after enable drops
            DRAIN: begin
                gc_d         = gc_q + GC_W'(pair_inc);
                state_d      = GAP;
                gap_tmr_d    = '0;
                frame_done_d = 1'b1;
                frame_ok_d   = !abort && (gc_d == GC_FULL);
            end
            GAP: begin
                if (gap_tmr_q == GAP_LAST) begin
                    if (continuous) begin
                        state_d    = ARM;
                        sync_tmr_d = '0;
                        gc_d       = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_tmr_d = gap_tmr_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        deser_en_d = (state_d == ACTIVE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk_75mhz) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_tmr_q   <= '0;
            cyc_cnt_q    <= '0;
            gap_tmr_q    <= '0;
            gc_q         <= '0;
            start_ack_q  <= 1'b0;
            deser_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_tmr_q   <= sync_tmr_d;
            cyc_cnt_q    <= cyc_cnt_d;
            gap_tmr_q    <= gap_tmr_d;
            gc_q         <= gc_d;
            start_ack_q  <= start_ack_d;
            deser_en_q   <= deser_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_to_q     <= err_to_d;
        end
    end

    assign start_ack    = start_ack_q;
    assign deser_enable = deser_en_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign frame_ok     = frame_ok_q;
    assign err_timeout  = err_to_q;
    assign group_count  = gc_q;

`ifdef CUSTOM_IP_SEQ_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = sat_inc16(frame_cnt_q, frame_done_d);
        err_cnt_d   = sat_inc16(err_cnt_q, err_to_d || (frame_done_d && !frame_ok_d));
    end

    always_ff @(posedge clk_75mhz) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_custom_ip_frame_sequencer.sv
// Randomized bench for custom_ip_frame_sequencer with a nibble-level deserializer model and frame scoreboard.
module tb_custom_ip_frame_sequencer;
    import custom_ip_pkg::*;

    localparam int FG     = SEQ_FRAME_GROUPS;
    localparam int EN_LEN = FG * NIBBLES_PER_GROUP;
    localparam int GAP_N  = 8;
    localparam int TMO    = 1024;
    localparam int GW     = $clog2(FG + 1);

    logic clk_75mhz = 1'b0;
    logic rst, start_req, continuous, abort, sync_in, pair_valid;
    logic start_ack, deser_enable, busy, frame_done, frame_ok, err_timeout;
    logic [GW-1:0] group_count;
`ifdef CUSTOM_IP_SEQ_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    custom_ip_frame_sequencer dut (
        .clk_75mhz   (clk_75mhz),
        .rst         (rst),
        .start_req   (start_req),
        .continuous  (continuous),
        .abort       (abort),
        .sync_in     (sync_in),
        .pair_valid  (pair_valid),
        .start_ack   (start_ack),
        .deser_enable(deser_enable),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_timeout (err_timeout),
        .group_count (group_count)
`ifdef CUSTOM_IP_SEQ_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk_75mhz = ~clk_75mhz;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack, n_done, n_bad, n_to;
    int en_run, low_run, last_en_len, last_low, n_en_frames;
    int exp_pairs, drop_idx, pair_idx_prev;
    bit prev_en, phase3_prev, noise_en, extra_en, busy_low_seen;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT after the edge, update the scoreboard and drive the deserializer model.
    task automatic tick();
        logic abort_in_cycle;
        abort_in_cycle = abort;
        @(posedge clk_75mhz);
        #1;
        if (start_ack) n_ack++;
        if (frame_done) n_done++;
        if (frame_done && !frame_ok) n_bad++;
        if (err_timeout) n_to++;
        if (!busy) busy_low_seen = 1'b1;

        if (deser_enable && !prev_en) begin
            if (n_en_frames > 0) last_low = low_run;
            en_run    = 0;
            exp_pairs = 0;
        end
        if (deser_enable) begin
            en_run++;
            low_run = 0;
        end else begin
            low_run++;
            if (prev_en) begin
                last_en_len = en_run;
                n_en_frames++;
            end
        end

        pair_valid = phase3_prev && (pair_idx_prev != drop_idx);
        if (extra_en && deser_enable && !pair_valid && $urandom_range(0, 7) == 0) pair_valid = 1'b1;
        if (noise_en && !deser_enable && !prev_en) pair_valid = ($urandom_range(0, 5) == 0);
        if (deser_enable || (prev_en && !abort_in_cycle)) exp_pairs += int'(pair_valid);

        phase3_prev   = deser_enable && (en_run % NIBBLES_PER_GROUP == 0);
        pair_idx_prev = en_run / NIBBLES_PER_GROUP - 1;
        prev_en       = deser_enable;
        sync_in       = noise_en && deser_enable && ($urandom_range(0, 15) == 0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!frame_done && k < budget) begin
            tick();
            k++;
        end
        chk_eq("frame_done_seen", frame_done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_ack"}, start_ack, 0);
        chk_eq({tag, "_en"}, deser_enable, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_done"}, frame_done, 0);
        chk_eq({tag, "_ok"}, frame_ok, 0);
        chk_eq({tag, "_to"}, err_timeout, 0);
        chk_eq({tag, "_gc"}, group_count, 0);
`ifdef CUSTOM_IP_SEQ_STATS_EN
        chk_eq({tag, "_fcnt"}, frame_cnt, 0);
        chk_eq({tag, "_ecnt"}, err_cnt, 0);
`endif
    endtask

    task automatic do_frame(input int drop, input bit extra, input string tag);
        int exp_gc;
        drop_idx = drop;
        extra_en = extra;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        chk_eq({tag, "_ack"}, start_ack, 1);
        repeat ($urandom_range(1, 20)) tick();
        sync_in = 1'b1;
        tick();
        chk_eq({tag, "_en_rise"}, deser_enable, 1);
        wait_done(EN_LEN + 8);
        exp_gc = (exp_pairs > FG) ? FG : exp_pairs;
        chk_eq({tag, "_en_len"}, last_en_len, EN_LEN);
        chk_eq({tag, "_gc"}, group_count, exp_gc);
        chk_eq({tag, "_ok"}, frame_ok, exp_gc == FG);
        drop_idx = -1;
        extra_en = 1'b0;
        repeat (GAP_N) tick();
        chk_eq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int k, ab, acks0, done0;
        rst = 1'b1; start_req = 1'b0; continuous = 1'b0; abort = 1'b0;
        sync_in = 1'b0; pair_valid = 1'b0;
        drop_idx = -1; pair_idx_prev = -1;
        n_ack = 0; n_done = 0; n_bad = 0; n_to = 0;
        en_run = 0; low_run = 0; last_en_len = 0; last_low = 0; n_en_frames = 0; exp_pairs = 0;
        prev_en = 0; phase3_prev = 0; noise_en = 0; extra_en = 0; busy_low_seen = 0;

        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        noise_en = 1'b1;
        repeat (5) tick();
        chk_eq("idle_noise_busy", busy, 0);
        chk_eq("idle_noise_done", n_done, 0);

        // Full frame with start_req held: ignored while busy, re-fires once back in IDLE
        start_req = 1'b1;
        tick();
        chk_eq("held_ack", start_ack, 1);
        chk_eq("held_busy", busy, 1);
        repeat ($urandom_range(1, 20)) tick();
        sync_in = 1'b1;
        tick();
        chk_eq("held_en_rise", deser_enable, 1);
        wait_done(EN_LEN + 8);
        chk_eq("held_en_len", last_en_len, EN_LEN);
        chk_eq("held_ok", frame_ok, 1);
        chk_eq("held_gc", group_count, FG);
        chk_eq("held_gc_model", group_count, exp_pairs);
        chk_eq("held_ack_once", n_ack, 1);
        k = 0;
        while (!start_ack && k < 30) begin
            tick();
            k++;
        end
        chk_eq("refire_delay", k, GAP_N + 1);
        start_req = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("arm_abort_busy", busy, 0);
        chk_eq("arm_abort_done", frame_done, 0);

        do_frame(-1, 1'b0, "plain");
        do_frame($urandom_range(0, FG - 1), 1'b0, "drop");
        chk_eq("drop_ok_flag", frame_ok, 0);
        do_frame(-1, 1'b1, "extra_sat");

        // Sync timeout
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        chk_eq("to_ack", start_ack, 1);
        k = 0;
        while (!err_timeout && k < TMO + 50) begin
            tick();
            k++;
        end
        chk_eq("to_latency", k, TMO);
        chk_eq("to_busy", busy, 0);
        chk_eq("to_en", deser_enable, 0);

        // Sync on the final ARM cycle beats the timeout
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat (TMO - 1) tick();
        sync_in = 1'b1;
        tick();
        chk_eq("late_sync_to", err_timeout, 0);
        chk_eq("late_sync_en", deser_enable, 1);
        wait_done(EN_LEN + 8);
        chk_eq("late_sync_ok", frame_ok, 1);
        repeat (GAP_N) tick();

        // abort and sync together in ARM: abort wins
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat ($urandom_range(1, 10)) tick();
        sync_in = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("abort_sync_en", deser_enable, 0);
        chk_eq("abort_sync_busy", busy, 0);
        chk_eq("abort_sync_done", frame_done, 0);

        // abort mid-ACTIVE, once at cycle 100 and once at a random cycle
        for (int r = 0; r < 2; r++) begin
            ab = (r == 0) ? 100 : $urandom_range(1, EN_LEN - 2);
            start_req = 1'b1;
            tick();
            start_req = 1'b0;
            repeat ($urandom_range(1, 10)) tick();
            sync_in = 1'b1;
            tick();
            k = 0;
            while (en_run < ab + 1 && k < EN_LEN) begin
                tick();
                k++;
            end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk_eq("abort_en", deser_enable, 0);
            chk_eq("abort_done", frame_done, 1);
            chk_eq("abort_ok", frame_ok, 0);
            chk_eq("abort_gc", group_count, exp_pairs);
            k = 0;
            while (busy && k < 30) begin
                tick();
                k++;
            end
            chk_eq("abort_gap", k, GAP_N);
        end

        // Continuous: two frames, one request
        continuous = 1'b1;
        acks0 = n_ack;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        busy_low_seen = 1'b0;
        repeat ($urandom_range(1, 10)) tick();
        sync_in = 1'b1;
        tick();
        wait_done(EN_LEN + 8);
        chk_eq("cont1_ok", frame_ok, 1);
        repeat (GAP_N + $urandom_range(0, 10)) tick();
        sync_in = 1'b1;
        tick();
        chk_eq("cont2_en", deser_enable, 1);
        continuous = 1'b0;
        wait_done(EN_LEN + 8);
        chk_eq("cont2_ok", frame_ok, 1);
        chk_eq("cont2_len", last_en_len, EN_LEN);
        chk_eq("cont_acks", n_ack - acks0, 1);
        chk_eq("cont_gap_min", last_low >= GAP_N, 1);
        chk_eq("cont_busy_held", busy_low_seen, 0);
        repeat (GAP_N) tick();
        chk_eq("cont_end_busy", busy, 0);

`ifdef CUSTOM_IP_SEQ_STATS_EN
        chk_eq("stats_frames", frame_cnt, n_done);
        chk_eq("stats_errs", err_cnt, n_bad + n_to);
`endif

        // Reset in the middle of ACTIVE
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat ($urandom_range(1, 10)) tick();
        sync_in = 1'b1;
        tick();
        repeat ($urandom_range(10, 500)) tick();
        chk_eq("pre_rst_en", deser_enable, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("mid_rst");
        rst = 1'b0;
        done0 = n_done;
        repeat (GAP_N + 4) tick();
        chk_eq("mid_rst_no_done", n_done, done0);
        chk_eq("mid_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
